noc1_req_arbiter: RTL and testbench
===================================

// Module: noc1_req_arbiter
// PURPOSE
//  Shares the single noc1encoder request port between NUM_REQ requesters: the L1.5 noc1buffer and the CSM ticket engine by default.
//  Round-robin grant with a starvation override. Grant is locked until the encoder acks. Honours dmbr_l15_stall before issuing a grant.
//  Sits between the requesters and noc1encoder inside l15; the requesters' own ack ports are fed from this block.
// PARAMETERS
//  NUM_REQ        2    number of requesters; index 0 = noc1buffer, 1 = csm
//  PAYLOAD_WIDTH  192  packed request: data_0/data_1/type/mshrid/address/size/nc/homeid
//  MAX_WAIT       15   cycles a pending requester may lose before it is forced to win
// PORTS
//  clk                        in   1                      clock
//  rst_n                      in   1                      reset, asynchronous, active-low
//  req_val                    in   NUM_REQ                per-requester valid; held until matching req_ack
//  req_payload                in   NUM_REQ*PAYLOAD_WIDTH  per-requester packed request
//  req_ack                    out  NUM_REQ                one-cycle pulse: request consumed by encoder
//  dmbr_l15_stall             in   1                      blocks new grants (not the in-flight request)
//  arb_noc1encoder_req_val    out  1                      request valid to encoder
//  arb_noc1encoder_req_data   out  PAYLOAD_WIDTH          registered payload of granted requester
//  noc1encoder_arb_req_ack    in   1                      encoder accepted the current request
//  arb_grant_id               out  $clog2(NUM_REQ)        index of current or last grantee
//  arb_starve_event           out  1                      pulse when the starvation override fires
// BEHAVIOUR
//  Reset: every output is 0, FSM=IDLE, rr_ptr=0, all wait counters=0.
//  FSM IDLE:
//   - If no stall and |req_val, pick a winner, latch payload and grant id, go BUSY.
//   - arb_noc1encoder_req_val rises the next cycle, so request-to-valid latency is 1 cycle.
//  FSM BUSY:
//   - val=1 and data held stable.
//   - On noc1encoder_arb_req_ack: pulse req_ack[grant] in the same cycle (combinational from ack & BUSY).
//   - Deassert val the next cycle and go IDLE.
//   - Back-to-back grants are therefore separated by >=1 IDLE cycle.
//  Pick order:
//   - Any requester with wait_cnt==MAX_WAIT wins; the lowest index wins ties. Pulse arb_starve_event.
//   - Otherwise round-robin from rr_ptr.
//   - After a grant, rr_ptr = winner+1, wrapping at NUM_REQ.
//  Wait counters:
//   - wait_cnt[i] increments when req_val[i] and i is not granted in an IDLE pick cycle.
//   - Saturates at MAX_WAIT.
//   - Clears on grant to i or when req_val[i]=0.
//  Stall: dmbr_l15_stall=1 in IDLE holds IDLE and freezes the wait counters. A stall in BUSY has no effect.
//  Requester protocol errors are assertions in the bench; the RTL does not act on them.
//   - A requester dropping val while granted: the latched payload is still sent.
//   - Data changing under val: the new data is ignored until the next grant.
//  Ack arriving in IDLE is ignored; req_ack stays 0.
//  Single requester present: granted every other cycle at best, since the IDLE gap is mandatory.
//  Reset mid-BUSY:
//   - The in-flight request is dropped with no req_ack; the requester keeps val and is re-arbitrated after reset.
//   - The encoder is reset by the same rst_n.
// STRUCTURE
//  Package noc1_arb_pkg:
//   - arb_state_e {IDLE, BUSY}
//   - NOC1_ARB_PAYLOAD_WIDTH
//   - payload struct: field order data_0, data_1, type, mshrid, address, size, nc, homeid
//  Sub-module noc1_rr_pick, combinational: req, rr_ptr, starve mask -> onehot winner, index, starve flag.
//  Top holds the FSM, payload/grant registers, wait counters and rr_ptr.
// TESTING
//  1. Reset, then only req_val=01 with payload P0, encoder acks 2 cycles after val:
//     -> val at T+1, data=P0, req_ack=01 pulse, val low the next cycle.
//  2. req_val=11 held, encoder acks immediately:
//     -> grants alternate 0,1,0,1; arb_grant_id toggles; no starve event.
//  3. MAX_WAIT=3, req 0 persistent, req 1 asserted, stall=0:
//     -> grant sequence stays fair; force rr_ptr bias via stall windows -> req 1 wins with arb_starve_event=1 after exactly 3 losses.
//  4. dmbr_l15_stall=1 for 10 cycles with req_val=11 in IDLE:
//     -> no val, wait counters frozen; stall asserted in BUSY -> request still completes on ack.
//  5. rst_n pulled low while BUSY:
//     -> all outputs 0 asynchronously, no req_ack; after release the same requester is re-granted with its unchanged payload.
//  6. Spurious noc1encoder_arb_req_ack in IDLE:
//     -> req_ack stays 00; data of the next grant is correct.

Source files
------------

// File: rtl/noc1_arb_pkg.sv
// Shared types and widths for the noc1 request arbiter slice.
package noc1_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Field order matches the noc1encoder request bundle, MSB first.
    typedef struct packed {
        logic [63:0] data_0;
        logic [63:0] data_1;
        logic [4:0]  req_type;
        logic [7:0]  mshrid;
        logic [39:0] address;
        logic [2:0]  size;
        logic        nc;
        logic [6:0]  homeid;
    } noc1_payload_t;

    localparam int unsigned NOC1_ARB_PAYLOAD_WIDTH = $bits(noc1_payload_t);

endpackage

// File: rtl/noc1_rr_pick.sv
// Combinational winner select: starving requesters first (lowest index), else round-robin from rr_ptr.
module noc1_rr_pick #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    input  logic [NUM_REQ-1:0]         starve,
    output logic [NUM_REQ-1:0]         winner_oh_c,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx_c,
    output logic                       starve_c
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] starve_req;
    logic               found;
    int unsigned        cand;

    always_comb begin
        starve_req   = req & starve;
        starve_c     = |starve_req;
        found        = 1'b0;
        cand         = 0;
        winner_idx_c = '0;
        winner_oh_c  = '0;
        if (starve_c) begin
            // Descending scan so the lowest starving index is the last write.
            for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
                if (starve_req[i]) begin
                    winner_idx_c = IDX_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = 32'(rr_ptr) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!found && req[cand]) begin
                    found        = 1'b1;
                    winner_idx_c = IDX_W'(cand);
                end
            end
        end
        if (|req) begin
            winner_oh_c[winner_idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/noc1_req_arbiter.sv
// Arbitrates the single noc1encoder request port between NUM_REQ requesters.
// Grant is held until the encoder acks; a mandatory IDLE cycle separates grants.
module noc1_req_arbiter
    import noc1_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned PAYLOAD_WIDTH = NOC1_ARB_PAYLOAD_WIDTH,
    parameter int unsigned MAX_WAIT      = 15
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_val,
    input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0]   req_payload,
    output logic [NUM_REQ-1:0]                 req_ack,
    input  logic                               dmbr_l15_stall,
    output logic                               arb_noc1encoder_req_val,
    output logic [PAYLOAD_WIDTH-1:0]           arb_noc1encoder_req_data,
    input  logic                               noc1encoder_arb_req_ack,
    output logic [$clog2(NUM_REQ)-1:0]         arb_grant_id,
    output logic                               arb_starve_event
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [0:0]  ST_IDLE = ARB_IDLE;
    localparam logic [0:0]  ST_BUSY = ARB_BUSY;

    logic [0:0]               state_q, state_d;
    logic                     val_q, val_d;
    logic [PAYLOAD_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic                     starve_q, starve_d;
    logic [CNT_W-1:0]         wait_q [NUM_REQ];
    logic [CNT_W-1:0]         wait_d [NUM_REQ];

    logic [NUM_REQ-1:0]       starve_mask;
    logic [NUM_REQ-1:0]       win_oh;
    logic [IDX_W-1:0]         win_idx;
    logic                     win_starve;
    logic                     pick;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            starve_mask[i] = (wait_q[i] == CNT_W'(MAX_WAIT));
        end
    end

    noc1_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req          (req_val),
        .rr_ptr       (rr_q),
        .starve       (starve_mask),
        .winner_oh_c  (win_oh),
        .winner_idx_c (win_idx),
        .starve_c     (win_starve)
    );

    // Next-state, grant capture and wait-counter update.
    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        data_d   = data_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        starve_d = 1'b0;
        wait_d   = wait_q;
        pick     = (state_q == ST_IDLE) && !dmbr_l15_stall && (|req_val);

        case (state_q)
            ST_IDLE: begin
                if (pick) begin
                    state_d  = ST_BUSY;
                    val_d    = 1'b1;
                    data_d   = req_payload[32'(win_idx) * PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                    grant_d  = win_idx;
                    starve_d = win_starve;
                    rr_d     = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                end
            end
            ST_BUSY: begin
                if (noc1encoder_arb_req_ack) begin
                    state_d = ST_IDLE;
                    val_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                val_d   = 1'b0;
            end
        endcase

        // Counters only move in a pick cycle, so a stall in IDLE freezes them.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!req_val[i]) begin
                wait_d[i] = '0;
            end else if (pick) begin
                if (win_oh[i]) begin
                    wait_d[i] = '0;
                end else if (wait_q[i] != CNT_W'(MAX_WAIT)) begin
                    wait_d[i] = wait_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            val_q    <= 1'b0;
            data_q   <= '0;
            grant_q  <= '0;
            rr_q     <= '0;
            starve_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            wait_q   <= wait_d;
        end
    end

    // Requester ack is same-cycle with the encoder ack so the requester can drop val on the next edge.
    always_comb begin
        req_ack = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ack[i] = (state_q == ST_BUSY) && noc1encoder_arb_req_ack && (grant_q == IDX_W'(i));
        end
    end

    assign arb_noc1encoder_req_val  = val_q;
    assign arb_noc1encoder_req_data = data_q;
    assign arb_grant_id             = grant_q;
    assign arb_starve_event         = starve_q;

endmodule

// File: tb/tb_noc1_req_arbiter.sv
// Directed bench for noc1_req_arbiter: 4 requesters, MAX_WAIT=3 so the starvation override is reachable.
module tb_noc1_req_arbiter;
    import noc1_arb_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned MW = 3;
    localparam int unsigned PW = NOC1_ARB_PAYLOAD_WIDTH;
    localparam int unsigned IW = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_val;
    logic [NR*PW-1:0]  req_payload;
    logic [NR-1:0]     req_ack;
    logic              stall;
    logic              enc_val;
    logic [PW-1:0]     enc_data;
    logic              enc_ack;
    logic [IW-1:0]     grant_id;
    logic              starve_ev;

    logic [PW-1:0]     pay [NR];
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NR); i++) begin
            req_payload[i*PW +: PW] = pay[i];
        end
    end

    noc1_req_arbiter #(
        .NUM_REQ       (NR),
        .PAYLOAD_WIDTH (PW),
        .MAX_WAIT      (MW)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .req_val                  (req_val),
        .req_payload              (req_payload),
        .req_ack                  (req_ack),
        .dmbr_l15_stall           (stall),
        .arb_noc1encoder_req_val  (enc_val),
        .arb_noc1encoder_req_data (enc_data),
        .noc1encoder_arb_req_ack  (enc_ack),
        .arb_grant_id             (grant_id),
        .arb_starve_event         (starve_ev)
    );

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [PW-1:0] mk(input logic [7:0] id, input logic [7:0] salt);
        noc1_payload_t p;
        p.data_0   = {8{id}};
        p.data_1   = {8{salt}};
        p.req_type = id[4:0];
        p.mshrid   = salt;
        p.address  = {32'hA000_0000, id};
        p.size     = 3'd3;
        p.nc       = salt[0];
        p.homeid   = id[6:0] ^ salt[6:0];
        return p;
    endfunction

    function automatic logic [NR-1:0] oh(input int id);
        logic [NR-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Wait (bounded) for val, check the grant, ack immediately and check the mandatory IDLE gap.
    task automatic expect_grant(input string tag, input int id, input logic [PW-1:0] exp_pl,
                                input logic exp_st);
        int n;
        n = 0;
        while (!enc_val && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, PW'(n < 20), PW'(1));
        chk({tag, "_id"}, PW'(grant_id), PW'(id));
        chk({tag, "_data"}, enc_data, exp_pl);
        chk({tag, "_starve"}, PW'(starve_ev), PW'(exp_st));
        enc_ack = 1'b1;
        #1;
        chk({tag, "_ack"}, PW'(req_ack), PW'(oh(id)));
        tick();
        enc_ack = 1'b0;
        chk({tag, "_gap"}, PW'(enc_val), PW'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        req_val = '0;
        stall   = 1'b0;
        enc_ack = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            pay[i] = mk(8'(i), 8'h10);
        end
        tick();
        tick();
        chk("rst_val", PW'(enc_val), PW'(0));
        chk("rst_data", enc_data, PW'(0));
        chk("rst_id", PW'(grant_id), PW'(0));
        chk("rst_starve", PW'(starve_ev), PW'(0));
        chk("rst_ack", PW'(req_ack), PW'(0));
        rst_n = 1'b1;
        tick();

        // 1: single requester, 1-cycle latency, data held while requester changes it, ack 2 cycles later
        req_val = 4'b0001;
        chk("t1_pre", PW'(enc_val), PW'(0));
        tick();
        chk("t1_val", PW'(enc_val), PW'(1));
        chk("t1_data", enc_data, mk(8'd0, 8'h10));
        chk("t1_id", PW'(grant_id), PW'(0));
        pay[0] = mk(8'd0, 8'h77);
        tick();
        chk("t1_hold", enc_data, mk(8'd0, 8'h10));
        tick();
        enc_ack = 1'b1;
        #1;
        chk("t1_ack", PW'(req_ack), PW'(4'b0001));
        chk("t1_val2", PW'(enc_val), PW'(1));
        tick();
        enc_ack = 1'b0;
        req_val = '0;
        chk("t1_drop", PW'(enc_val), PW'(0));
        chk("t1_ack0", PW'(req_ack), PW'(0));
        tick();

        // 2: two requesters, rr_ptr=1 after test 1 -> 1,0,1,0 with no starvation
        req_val = 4'b0011;
        expect_grant("t2a", 1, pay[1], 1'b0);
        expect_grant("t2b", 0, pay[0], 1'b0);
        expect_grant("t2c", 1, pay[1], 1'b0);
        expect_grant("t2d", 0, pay[0], 1'b0);
        req_val = '0;
        tick();

        // 3: all four request from rr_ptr=1; requester 0 loses 3 times then is forced
        req_val = 4'b1111;
        expect_grant("t3a", 1, pay[1], 1'b0);
        expect_grant("t3b", 2, pay[2], 1'b0);
        expect_grant("t3c", 3, pay[3], 1'b0);
        expect_grant("t3d", 0, pay[0], 1'b1);
        expect_grant("t3e", 1, pay[1], 1'b1);
        req_val = '0;
        tick();

        // 4: stall in IDLE blocks grants and freezes counters; stall in BUSY does not block completion
        stall   = 1'b1;
        req_val = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_stall_val", PW'(enc_val), PW'(0));
        end
        stall = 1'b0;
        tick();
        chk("t4_val", PW'(enc_val), PW'(1));
        chk("t4_id", PW'(grant_id), PW'(0));
        chk("t4_starve", PW'(starve_ev), PW'(0));
        stall = 1'b1;
        tick();
        tick();
        chk("t4_busy_val", PW'(enc_val), PW'(1));
        enc_ack = 1'b1;
        #1;
        chk("t4_ack", PW'(req_ack), PW'(4'b0001));
        tick();
        enc_ack = 1'b0;
        chk("t4_done", PW'(enc_val), PW'(0));
        tick();
        chk("t4_hold_idle", PW'(enc_val), PW'(0));
        stall = 1'b0;
        expect_grant("t4b", 1, pay[1], 1'b0);
        req_val = '0;
        tick();

        // 5: reset while BUSY drops the request; same requester re-granted with unchanged payload
        req_val = 4'b0100;
        tick();
        chk("t5_val", PW'(enc_val), PW'(1));
        chk("t5_id", PW'(grant_id), PW'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_val", PW'(enc_val), PW'(0));
        chk("t5_rst_data", enc_data, PW'(0));
        chk("t5_rst_id", PW'(grant_id), PW'(0));
        enc_ack = 1'b1;
        #1;
        chk("t5_rst_ack", PW'(req_ack), PW'(0));
        tick();
        enc_ack = 1'b0;
        rst_n   = 1'b1;
        expect_grant("t5b", 2, mk(8'd2, 8'h10), 1'b0);
        req_val = '0;
        tick();

        // 6: spurious encoder ack in IDLE is ignored
        enc_ack = 1'b1;
        #1;
        chk("t6_spur_ack", PW'(req_ack), PW'(0));
        tick();
        enc_ack = 1'b0;
        chk("t6_idle", PW'(enc_val), PW'(0));
        pay[3]  = mk(8'd3, 8'hC5);
        req_val = 4'b1000;
        expect_grant("t6b", 3, mk(8'd3, 8'hC5), 1'b0);
        req_val = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
